// File: rtl/victim_wb_buffer_if.sv
// Bus bundle for the victim writeback buffer: cache-side push/lookup plus AXI AW/W/B.
// The slave modport is the buffer's view and the master modport is the environment's view.
interface victim_wb_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
);
    logic                             push_valid;
    logic                             push_ready;
    logic [ADDR_WIDTH-1:0]            push_addr;
    logic [LINE_WORDS*DATA_WIDTH-1:0] push_data;
    logic                             busy;
    logic [ADDR_WIDTH-1:0]            lookup_addr;
    logic                             conflict;
    logic                             awvalid;
    logic                             awready;
    logic [ADDR_WIDTH-1:0]            awaddr;
    logic [7:0]                       awlen;
    logic [2:0]                       awsize;
    logic [1:0]                       awburst;
    logic                             wvalid;
    logic                             wready;
    logic [DATA_WIDTH-1:0]            wdata;
    logic [DATA_WIDTH/8-1:0]          wstrb;
    logic                             wlast;
    logic                             bvalid;
    logic                             bready;
    logic [1:0]                       bresp;
    logic                             wb_error;

    modport slave (
        input  push_valid, push_addr, push_data, lookup_addr,
        input  awready, wready, bvalid, bresp,
        output push_ready, busy, conflict,
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready, wb_error
    );

    modport master (
        output push_valid, push_addr, push_data, lookup_addr,
        output awready, wready, bvalid, bresp,
        input  push_ready, busy, conflict,
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready, wb_error
    );
endinterface

// File: rtl/victim_wb_buffer.sv
// Single-entry writeback buffer: holds one evicted dirty line and drains it as one
// AXI INCR burst (AW, LINE_WORDS W beats, B), flagging refill reads of that line.
module victim_wb_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    victim_wb_buffer_if.slave  bus
);
    localparam int OFF    = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  words_q [LINE_WORDS];
    logic                   accept;

    assign accept = (state_q == S_IDLE) && bus.push_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Line payload carries no reset; it is only observed while an entry is held.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= {bus.push_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            for (int i = 0; i < LINE_WORDS; i++) begin
                words_q[i] <= bus.push_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        bus.push_ready = 1'b0;
        bus.awvalid    = 1'b0;
        bus.wvalid     = 1'b0;
        bus.wlast      = 1'b0;
        bus.bready     = 1'b0;
        bus.wb_error   = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.push_ready = 1'b1;
                if (bus.push_valid) begin
                    state_d = S_AW;
                end
            end
            S_AW: begin
                bus.awvalid = 1'b1;
                if (bus.awready) begin
                    state_d = S_W;
                    beat_d  = '0;
                end
            end
            S_W: begin
                bus.wvalid = 1'b1;
                bus.wlast  = (beat_q == LAST_BEAT);
                if (bus.wready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    state_d      = S_IDLE;
                    bus.wb_error = (bus.bresp != 2'b00);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.conflict = bus.busy &&
                          (bus.lookup_addr[ADDR_WIDTH-1:OFF] == addr_q[ADDR_WIDTH-1:OFF]);

    // Burst attributes are fixed by the line geometry; only address and data vary.
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = 8'(LINE_WORDS - 1);
    assign bus.awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign bus.awburst = 2'b01;
    assign bus.wdata   = words_q[beat_q];
    assign bus.wstrb   = '1;
endmodule

// File: tb/tb_victim_wb_buffer.sv
// Scoreboard bench for victim_wb_buffer: stimulus queues the expected AW/W/B traffic,
// a monitor pops and compares on every handshake.
`define CHK(nm, a, e) check(nm, 128'(a), 128'(e))

module tb_victim_wb_buffer;
    logic clk;
    logic reset;

    victim_wb_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4)) bus ();

    victim_wb_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int w_hs    = 0;
    int err_cycles = 0;
    bit mon_en  = 0;

    logic [31:0] exp_aw [$];
    logic [32:0] exp_w  [$];
    logic        exp_b  [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_line(input logic [31:0] aw, input logic [127:0] d, input logic err);
        exp_aw.push_back(aw);
        for (int i = 0; i < 4; i++) exp_w.push_back({(i == 3), d[i*32 +: 32]});
        exp_b.push_back(err);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!bus.push_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.push_ready) `CHK("idle_timeout", 0, 1);
    endtask

    // Monitor: sample mid-cycle, away from the active edge.
    initial begin
        logic [32:0] w;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus.wb_error) err_cycles++;
            if (bus.awvalid && bus.awready) begin
                if (exp_aw.size() == 0) `CHK("aw_unexpected", 1, 0);
                else `CHK("aw_fields", {bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
                          {exp_aw.pop_front(), 8'd3, 3'd2, 2'b01});
            end
            if (bus.wvalid && bus.wready) begin
                w_hs++;
                if (exp_w.size() == 0) `CHK("w_unexpected", 1, 0);
                else begin
                    w = exp_w.pop_front();
                    `CHK("w_beat", {bus.wlast, bus.wdata, bus.wstrb}, {w, 4'hF});
                end
            end
            if (bus.bready && bus.bvalid) begin
                if (exp_b.size() == 0) `CHK("b_unexpected", 1, 0);
                else `CHK("b_wb_error", bus.wb_error, exp_b.pop_front());
            end
        end
    end

    initial begin
        int n, k, hs0, e0;
        bit ok, tog, stalled;
        logic [31:0] prev;

        reset           = 1'b1;
        bus.push_valid  = 1'b0;
        bus.push_addr   = '0;
        bus.push_data   = '0;
        bus.lookup_addr = '0;
        bus.awready     = 1'b1;
        bus.wready      = 1'b1;
        bus.bvalid      = 1'b1;
        bus.bresp       = 2'b00;
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        `CHK("reset_outputs", {bus.push_ready, bus.busy, bus.conflict, bus.awvalid,
                               bus.wvalid, bus.bready, bus.wlast, bus.wb_error}, 8'b1000_0000);

        // 1: basic burst, all readies high
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h1000_0034;
        bus.push_data  = {32'd4, 32'd3, 32'd2, 32'd1};
        expect_line(32'h1000_0030, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        tick();
        bus.push_valid = 1'b0;
        `CHK("t1_aw_after_push", {bus.awvalid, bus.wvalid, bus.push_ready}, 3'b100);
        wait_idle(n);
        `CHK("t1_occupancy", n, 6);

        // 2: AW stalled for 5 cycles
        bus.awready    = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h0000_1008;
        bus.push_data  = {32'h44, 32'h33, 32'h22, 32'h11};
        expect_line(32'h0000_1000, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
        tick();
        bus.push_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(bus.awvalid && bus.awaddr == 32'h0000_1000 && !bus.wvalid)) ok = 1'b0;
            tick();
        end
        `CHK("t2_aw_stall_stable", ok, 1);
        bus.awready = 1'b1;
        wait_idle(n);
        `CHK("t2_occupancy", n, 6);

        // 3: wready toggling
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h0000_2000;
        bus.push_data  = {32'hD, 32'hC, 32'hB, 32'hA};
        expect_line(32'h0000_2000, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0);
        hs0 = w_hs;
        tick();
        bus.push_valid = 1'b0;
        tick();
        tog = 1'b1;
        ok  = 1'b1;
        k   = 0;
        while (bus.busy && k < 40) begin
            stalled = 1'b0;
            prev    = bus.wdata;
            if (bus.wvalid) begin
                bus.wready = tog;
                stalled    = !tog;
                tog        = !tog;
            end else begin
                bus.wready = 1'b1;
            end
            tick();
            if (stalled && bus.wdata !== prev) ok = 1'b0;
            k++;
        end
        bus.wready = 1'b1;
        `CHK("t3_wdata_hold", ok, 1);
        `CHK("t3_handshakes", w_hs - hs0, 4);
        `CHK("t3_back_idle", bus.push_ready, 1);

        // 4: push offered during W is held off until after B
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h3000_0000;
        bus.push_data  = {32'h104, 32'h103, 32'h102, 32'h101};
        expect_line(32'h3000_0000, {32'h104, 32'h103, 32'h102, 32'h101}, 1'b0);
        tick();
        bus.push_valid = 1'b0;
        tick();
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h3000_0118;
        bus.push_data  = {32'h204, 32'h203, 32'h202, 32'h201};
        expect_line(32'h3000_0110, {32'h204, 32'h203, 32'h202, 32'h201}, 1'b0);
        `CHK("t4_ready_low_in_W", {bus.wvalid, bus.push_ready}, 2'b10);
        wait_idle(n);
        `CHK("t4_wait_cycles", n, 5);
        tick();
        bus.push_valid = 1'b0;
        `CHK("t4_accept_after_B", {bus.busy, bus.awvalid}, 2'b11);
        wait_idle(n);
        `CHK("t4_second_occupancy", n, 6);

        // 5: line-address conflict
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h2000_0040;
        bus.push_data  = {32'h54, 32'h53, 32'h52, 32'h51};
        expect_line(32'h2000_0040, {32'h54, 32'h53, 32'h52, 32'h51}, 1'b0);
        tick();
        bus.push_valid  = 1'b0;
        bus.lookup_addr = 32'h2000_004C;
        #1;
        `CHK("t5_conflict_same_line", bus.conflict, 1);
        bus.lookup_addr = 32'h2000_0050;
        #1;
        `CHK("t5_conflict_next_line", bus.conflict, 0);
        bus.lookup_addr = 32'h2000_0040;
        k = 0;
        while (!bus.push_ready && k < 50) begin
            if (bus.bready) `CHK("t5_conflict_in_B", bus.conflict, 1);
            tick();
            k++;
        end
        `CHK("t5_conflict_after_B", {bus.push_ready, bus.conflict}, 2'b10);
        bus.lookup_addr = '0;

        // 6a: error response pulses wb_error for one cycle
        bus.bresp      = 2'b10;
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h4000_0020;
        bus.push_data  = {32'h64, 32'h63, 32'h62, 32'h61};
        expect_line(32'h4000_0020, {32'h64, 32'h63, 32'h62, 32'h61}, 1'b1);
        e0 = err_cycles;
        tick();
        bus.push_valid = 1'b0;
        wait_idle(n);
        bus.bresp = 2'b00;
        tick();
        `CHK("t6_err_pulse_cycles", err_cycles - e0, 1);
        `CHK("t6_err_low_after", bus.wb_error, 0);

        // 6b: reset in the middle of W abandons the burst
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h5000_0000;
        bus.push_data  = {32'h74, 32'h73, 32'h72, 32'h71};
        exp_aw.push_back(32'h5000_0000);
        exp_w.push_back({1'b0, 32'h71});
        exp_w.push_back({1'b0, 32'h72});
        tick();
        bus.push_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        `CHK("t6_reset_mid_W", {bus.push_ready, bus.busy, bus.awvalid, bus.wvalid,
                                bus.bready, bus.wlast}, 6'b100000);
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h5000_0044;
        bus.push_data  = {32'h84, 32'h83, 32'h82, 32'h81};
        expect_line(32'h5000_0040, {32'h84, 32'h83, 32'h82, 32'h81}, 1'b0);
        tick();
        bus.push_valid = 1'b0;
        wait_idle(n);
        `CHK("t6_recovery_occupancy", n, 6);

        tick();
        `CHK("sb_drained", exp_aw.size() + exp_w.size() + exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
